// File: rtl/mem_multibank_pkg.sv
// Shared constants and types for the interleaved multi-bank buffer memory.
// Collision policies, clear-FSM state encoding and the read-latency ceiling.
package mem_multibank_pkg;

  localparam int WRITE_FIRST      = 1;
  localparam int READ_FIRST       = 0;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    MEM_STATE_IDLE  = 1'b0,
    MEM_STATE_CLEAR = 1'b1
  } mem_state_e;

  // Index width for an array of 'depth' entries, never narrower than one bit.
  function automatic int index_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_multibank_bank.sv
// One simple dual-port bank: byte-enabled write port, registered read port.
// Read-during-write to the same row returns the old word (read-first).
module mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 16384,
  parameter int ROW_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ROW_WIDTH-1:0]    wr_row,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    re,
  input  logic [ROW_WIDTH-1:0]    rd_row,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // NOTE: the array and its read register carry no reset so the bank maps onto block RAM.
  // NOTE: non-blocking assignments make the read sample the pre-write contents of the row.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_row][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (re) rd_data <= mem[rd_row];
  end

endmodule

// File: rtl/mem_multibank.sv
// Interleaved multi-bank buffer: byte-enable writes, tagged pipelined reads,
// defined same-address collision behaviour and a row-by-row clear sequencer.
module mem_multibank
  import mem_multibank_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_ADDRESSES   = 65536,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int LOG_NUM_BANKS   = 2,
  parameter int READ_LATENCY    = 1,
  parameter int WRITE_MODE      = 1,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_write,
  input  logic [LOG_MAX_ADDRESS-1:0] addr_write,
  input  logic [DATA_WIDTH/8-1:0]    be_write,
  input  logic                       write,
  input  logic [LOG_MAX_ADDRESS-1:0] addr_read,
  input  logic                       read,
  input  logic [TAG_WIDTH-1:0]       tag_read,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       valid_out,
  output logic [TAG_WIDTH-1:0]       tag_out,
  input  logic                       clear,
  output logic                       busy
);

  localparam int NUM_BANKS = 2 ** LOG_NUM_BANKS;
  localparam int ROWS      = NUM_ADDRESSES / NUM_BANKS;
  localparam int ROW_WIDTH = index_width(ROWS);
  localparam int LANES     = DATA_WIDTH / 8;

  localparam logic [LOG_MAX_ADDRESS:0] ADDR_LIMIT = (LOG_MAX_ADDRESS + 1)'(NUM_ADDRESSES);
  localparam logic [ROW_WIDTH-1:0]     ROW_LAST   = ROW_WIDTH'(ROWS - 1);

  // Clear sequencer
  mem_state_e           state, next_state;
  logic [ROW_WIDTH-1:0] row_cnt, row_next;
  logic                 idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MEM_STATE_IDLE;
      row_cnt <= '0;
    end else begin
      state   <= next_state;
      row_cnt <= row_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    row_next   = row_cnt;
    case (state)
      MEM_STATE_IDLE: begin
        if (clear) begin
          next_state = MEM_STATE_CLEAR;
          row_next   = '0;
        end
      end
      MEM_STATE_CLEAR: begin
        row_next = row_cnt + 1'b1;
        if (row_cnt == ROW_LAST) next_state = MEM_STATE_IDLE;
      end
      default: next_state = MEM_STATE_IDLE;
    endcase
  end

  assign idle = (state == MEM_STATE_IDLE);
  assign busy = ~idle;

  // Request decode
  logic [LOG_NUM_BANKS-1:0] wr_bank, rd_bank;
  logic [ROW_WIDTH-1:0]     wr_row, rd_row;
  logic                     wr_ok, rd_ok, rd_in_range, collision;

  assign wr_bank     = addr_write[LOG_NUM_BANKS-1:0];
  assign rd_bank     = addr_read[LOG_NUM_BANKS-1:0];
  assign wr_row      = ROW_WIDTH'(addr_write >> LOG_NUM_BANKS);
  assign rd_row      = ROW_WIDTH'(addr_read >> LOG_NUM_BANKS);
  assign rd_in_range = ({1'b0, addr_read} < ADDR_LIMIT);
  assign wr_ok       = write && idle && ({1'b0, addr_write} < ADDR_LIMIT);
  // A clear request from IDLE takes priority over a read in the same cycle.
  assign rd_ok       = read && idle && !clear;
  assign collision   = rd_ok && wr_ok && (addr_read == addr_write);

  // Banks: in CLEAR every bank zeroes the counter row in parallel.
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  bank_we, bank_re;
    logic [ROW_WIDTH-1:0]  bank_wr_row;
    logic [DATA_WIDTH-1:0] bank_wr_data;
    logic [LANES-1:0]      bank_be;

    always_comb begin
      bank_we      = wr_ok && (wr_bank == LOG_NUM_BANKS'(b));
      bank_wr_row  = wr_row;
      bank_wr_data = data_write;
      bank_be      = be_write;
      if (!idle) begin
        bank_we      = 1'b1;
        bank_wr_row  = row_cnt;
        bank_wr_data = '0;
        bank_be      = '1;
      end
    end

    assign bank_re = rd_ok && (rd_bank == LOG_NUM_BANKS'(b));

    mem_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ROWS      (ROWS),
      .ROW_WIDTH (ROW_WIDTH)
    ) u_bank (
      .clk    (clk),
      .we     (bank_we),
      .wr_row (bank_wr_row),
      .wr_data(bank_wr_data),
      .wr_be  (bank_be),
      .re     (bank_re),
      .rd_row (rd_row),
      .rd_data(bank_rd[b])
    );
  end

  // Front stage: side information registered alongside the bank read.
  logic                     f_valid, f_oor;
  logic [TAG_WIDTH-1:0]     f_tag;
  logic [LOG_NUM_BANKS-1:0] f_bank;
  logic [LANES-1:0]         f_fwd_mask;
  logic [DATA_WIDTH-1:0]    f_fwd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_valid    <= 1'b0;
      f_oor      <= 1'b0;
      f_tag      <= '0;
      f_bank     <= '0;
      f_fwd_mask <= '0;
      f_fwd_data <= '0;
    end else begin
      f_valid <= rd_ok;
      if (rd_ok) begin
        f_oor      <= !rd_in_range;
        f_tag      <= tag_read;
        f_bank     <= rd_bank;
        f_fwd_mask <= (WRITE_MODE == WRITE_FIRST && collision) ? be_write : '0;
        f_fwd_data <= data_write;
      end
    end
  end

  // Banks read-first; write-first mode overlays the colliding write lanes here.
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    merged = bank_rd[f_bank];
    for (int i = 0; i < LANES; i++) begin
      if (f_fwd_mask[i]) merged[i*8 +: 8] = f_fwd_data[i*8 +: 8];
    end
    if (f_oor) merged = '0;
  end

  // Output stages; data and tag only advance with a valid so the port holds.
  if (READ_LATENCY <= 1) begin : g_lat1
    logic [DATA_WIDTH-1:0] hold_data;
    logic [TAG_WIDTH-1:0]  hold_tag;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_data <= '0;
        hold_tag  <= '0;
      end else if (f_valid) begin
        hold_data <= merged;
        hold_tag  <= f_tag;
      end
    end

    assign valid_out = f_valid;
    assign data_read = f_valid ? merged : hold_data;
    assign tag_out   = f_valid ? f_tag : hold_tag;
  end else begin : g_pipe
    localparam int STAGES = READ_LATENCY - 1;

    logic [DATA_WIDTH-1:0] p_data  [STAGES];
    logic [TAG_WIDTH-1:0]  p_tag   [STAGES];
    logic                  p_valid [STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < STAGES; k++) begin
          p_data[k]  <= '0;
          p_tag[k]   <= '0;
          p_valid[k] <= 1'b0;
        end
      end else begin
        p_valid[0] <= f_valid;
        if (f_valid) begin
          p_data[0] <= merged;
          p_tag[0]  <= f_tag;
        end
        for (int k = 1; k < STAGES; k++) begin
          p_valid[k] <= p_valid[k-1];
          if (p_valid[k-1]) begin
            p_data[k] <= p_data[k-1];
            p_tag[k]  <= p_tag[k-1];
          end
        end
      end
    end

    assign valid_out = p_valid[STAGES-1];
    assign data_read = p_data[STAGES-1];
    assign tag_out   = p_tag[STAGES-1];
  end

`ifdef DEBUG
  logic [15:0] tics;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tics <= '0;
    else      tics <= tics + 16'd1;
  end

  always @(negedge clk) begin
    if (rst && valid_out) $display("MEM: cycle %d data_out %x tag %x", tics, data_read, tag_out);
  end
`endif

endmodule

// File: tb/tb_mem_multibank.sv
// Scoreboard bench: a write-first and a read-first instance share one directed
// stimulus stream; each read pushes its expected word, a monitor pops on valid_out.
module tb_mem_multibank;
  import mem_multibank_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TW  = 4;
  localparam int LAT = 2;
  localparam int NA  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_write = '0;
  logic [AW-1:0] addr_write = '0;
  logic [3:0]    be_write = '0;
  logic          write = 1'b0;
  logic [AW-1:0] addr_read = '0;
  logic          read = 1'b0;
  logic [TW-1:0] tag_read = '0;
  logic          clear = 1'b0;

  logic [DW-1:0] data_read, data_read_rf;
  logic          valid_out, valid_out_rf;
  logic [TW-1:0] tag_out, tag_out_rf;
  logic          busy, busy_rf;

  mem_multibank #(
    .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .LOG_MAX_ADDRESS(AW), .LOG_NUM_BANKS(2),
    .READ_LATENCY(LAT), .WRITE_MODE(WRITE_FIRST), .TAG_WIDTH(TW)
  ) u_dut (
    .clk(clk), .rst(rst), .data_write(data_write), .addr_write(addr_write),
    .be_write(be_write), .write(write), .addr_read(addr_read), .read(read),
    .tag_read(tag_read), .data_read(data_read), .valid_out(valid_out),
    .tag_out(tag_out), .clear(clear), .busy(busy)
  );

  mem_multibank #(
    .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .LOG_MAX_ADDRESS(AW), .LOG_NUM_BANKS(2),
    .READ_LATENCY(LAT), .WRITE_MODE(READ_FIRST), .TAG_WIDTH(TW)
  ) u_dut_rf (
    .clk(clk), .rst(rst), .data_write(data_write), .addr_write(addr_write),
    .be_write(be_write), .write(write), .addr_read(addr_read), .read(read),
    .tag_read(tag_read), .data_read(data_read_rf), .valid_out(valid_out_rf),
    .tag_out(tag_out_rf), .clear(clear), .busy(busy_rf)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t q_wf[$];
  exp_t q_rf[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every valid_out, otherwise verifies data_read holds.
  logic [DW-1:0] last_wf = '0;
  logic [DW-1:0] last_rf = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_wf = '0;
      last_rf = '0;
    end else begin
      if (valid_out) begin
        if (q_wf.size() == 0) check("wf_unexpected_valid", 1, 0);
        else begin
          e = q_wf.pop_front();
          check("wf_data", data_read, e.data);
          check("wf_tag", 32'(tag_out), 32'(e.tag));
          check("wf_latency", 32'(cyc), 32'(e.cyc + LAT));
          last_wf = e.data;
        end
      end else check("wf_hold", data_read, last_wf);
      if (valid_out_rf) begin
        if (q_rf.size() == 0) check("rf_unexpected_valid", 1, 0);
        else begin
          e = q_rf.pop_front();
          check("rf_data", data_read_rf, e.data);
          check("rf_tag", 32'(tag_out_rf), 32'(e.tag));
          check("rf_latency", 32'(cyc), 32'(e.cyc + LAT));
          last_rf = e.data;
        end
      end else check("rf_hold", data_read_rf, last_rf);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    addr_write = a; data_write = d; be_write = be; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic push_exp(input logic [TW-1:0] t, input logic [DW-1:0] ewf, input logic [DW-1:0] erf);
    exp_t e;
    e.tag = t; e.cyc = cyc;
    e.data = ewf; q_wf.push_back(e);
    e.data = erf; q_rf.push_back(e);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t,
                    input logic [DW-1:0] ewf, input logic [DW-1:0] erf);
    addr_read = a; tag_read = t; read = 1'b1;
    push_exp(t, ewf, erf);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be,
                    input logic [TW-1:0] t, input logic [DW-1:0] ewf, input logic [DW-1:0] erf);
    addr_write = a; data_write = d; be_write = be; write = 1'b1;
    addr_read = a; tag_read = t; read = 1'b1;
    push_exp(t, ewf, erf);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_wf.size() != 0 || q_rf.size() != 0) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_outstanding", 32'(q_wf.size() + q_rf.size()), 0);
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp_word;

    #12;
    check("rst_data_read", data_read, 0);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_tag_out", 32'(tag_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid_out_rf", 32'(valid_out_rf), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Full-word write then tagged read.
    wr(16'd5, 32'hDEADBEEF, 4'hF);
    rd(16'd5, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF);

    // Partial byte-enable write over an existing word.
    wr(16'd9, 32'h11223344, 4'hF);
    wr(16'd9, 32'hAABBCCDD, 4'b0101);
    rd(16'd9, 4'd1, 32'h11BB33DD, 32'h11BB33DD);

    // Same-address collision, then the updated word in both modes.
    rw(16'd9, 32'h000000FF, 4'h1, 4'd2, 32'h11BB33FF, 32'h11BB33DD);
    rd(16'd9, 4'd4, 32'h11BB33FF, 32'h11BB33FF);

    // be_write = 0 leaves the word untouched.
    wr(16'd9, 32'hFFFFFFFF, 4'h0);
    rd(16'd9, 4'd5, 32'h11BB33FF, 32'h11BB33FF);

    // One word per bank, then back-to-back reads across all four banks.
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'hC0DE0000 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) rd(AW'(i), TW'(i), 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(i));

    // Out-of-range write would alias addr 5 if not dropped; out-of-range reads return 0.
    wr(16'd69, 32'h12345678, 4'hF);
    rd(16'd5, 4'd6, 32'hDEADBEEF, 32'hDEADBEEF);
    rd(16'd69, 4'd7, 32'h0, 32'h0);
    rd(16'hFFFF, 4'd8, 32'h0, 32'h0);
    drain();

    // Clear with a simultaneous read (read dropped), plus a read/write issued mid-clear.
    addr_read = 16'd5; tag_read = 4'd9; read = 1'b1; clear = 1'b1;
    @(negedge clk);
    read = 1'b0; clear = 1'b0;
    check("clear_busy_start", 32'(busy), 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 8) begin
        addr_read = 16'd5; read = 1'b1;
        addr_write = 16'd6; data_write = 32'hBADC0FFE; be_write = 4'hF; write = 1'b1;
        clear = 1'b1;
      end else begin
        read = 1'b0; write = 1'b0; clear = 1'b0;
      end
      @(negedge clk);
    end
    read = 1'b0; write = 1'b0; clear = 1'b0;
    check("clear_busy_cycles", 32'(n), 16);
    check("clear_busy_rf_done", 32'(busy_rf), 0);
    for (int a = 0; a < NA; a++) rd(AW'(a), TW'(a), 32'h0, 32'h0);
    drain();

    // Fill, start a clear, reset after five rows have been zeroed.
    for (int a = 0; a < NA; a++) wr(AW'(a), 32'h10000000 | 32'(a), 4'hF);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midclear_rst_busy", 32'(busy), 0);
    check("midclear_rst_valid", 32'(valid_out), 0);
    check("midclear_rst_data", data_read, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    for (int a = 0; a < NA; a++) begin
      exp_word = (a < 20) ? 32'h0 : (32'h10000000 | 32'(a));
      rd(AW'(a), TW'(a), exp_word, exp_word);
    end
    drain();

    // A fresh clear after reset runs the full sequence again.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reclear_busy_cycles", 32'(n), 16);
    rd(16'd63, 4'd1, 32'h0, 32'h0);
    rd(16'd0, 4'd2, 32'h0, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_multibank.md
Name: mem_multibank

Overview:
- Parametrised successor of the single-bank BRAM memory: one write port and one read port over NUM_BANKS interleaved banks.
- Adds byte-enable writes, a configurable read pipeline latency and read-tag pass-through.
- Adds defined same-address read/write collision behaviour and a hardware clear sequencer.
- Sits between the RTLinf data movers and compute units as the buffer for weights and activations.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- NUM_ADDRESSES, 65536, total words; must be a multiple of NUM_BANKS.
- LOG_MAX_ADDRESS, 16, address width.
- LOG_NUM_BANKS, 2, log2 of bank count; NUM_BANKS = 2**LOG_NUM_BANKS.
- READ_LATENCY, 1, cycles from read to valid_out; legal range 1..4.
- WRITE_MODE, 1, collision policy: 1 = write-first (forward new data), 0 = read-first (old data).
- TAG_WIDTH, 4, width of the read tag carried alongside each read.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- data_write  in  DATA_WIDTH  write data.
- addr_write  in  LOG_MAX_ADDRESS  write address.
- be_write  in  DATA_WIDTH/8  byte enables; bit i covers byte lane i.
- write  in  1  write strobe.
- addr_read  in  LOG_MAX_ADDRESS  read address.
- read  in  1  read strobe.
- tag_read  in  TAG_WIDTH  tag returned with the read data.
- data_read  out  DATA_WIDTH  read data (registered).
- valid_out  out  1  data_read and tag_out are valid this cycle.
- tag_out  out  TAG_WIDTH  tag of the returned read.
- clear  in  1  single-cycle request to zero the whole memory.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset: rst low asynchronously forces data_read=0, valid_out=0, tag_out=0, busy=0, FSM=IDLE, row counter=0 and all pipeline valid bits=0. Memory contents are not reset.
- Address mapping: bank = addr[LOG_NUM_BANKS-1:0]; row = addr >> LOG_NUM_BANKS; ROWS = NUM_ADDRESSES/NUM_BANKS.
- Out-of-range addresses (addr >= NUM_ADDRESSES):
  - write is dropped;
  - read still returns valid_out with data_read=0.
- Write: on a clk edge with write=1 and busy=0, only the lanes with be_write[i]=1 are updated. be_write=0 is a no-op.
- Read timing:
  - read=1 sampled at edge N gives valid_out=1 after edge N+READ_LATENCY-1 (READ_LATENCY=1 is the same timing as the existing single-bank memory).
  - Fully pipelined: one read per cycle, returned in order; tag_out travels with its data.
  - data_read holds its last value when valid_out=0.
- Collision (read and write in the same cycle, same address):
  - WRITE_MODE=1: returned word = data_write in enabled lanes, old contents in the others.
  - WRITE_MODE=0: returned word = old contents.
  - Memory is updated in both modes.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clear=1. Row counter is loaded with 0 and busy=1 from the next cycle.
  - In CLEAR, all banks write 0 to the counter row each cycle and the counter increments.
  - After row ROWS-1 is written, go to IDLE; busy=0 the cycle after. The sequence lasts exactly ROWS cycles.
- While busy=1:
  - write and read are ignored; no new valid is issued.
  - Reads already in the pipeline drain normally.
  - clear=1 is ignored.
- clear and read in the same cycle from IDLE: clear wins and the read is dropped.
- Reset mid-clear: FSM returns to IDLE and memory is left partially cleared; a clear after reset restarts at row 0.
- DEBUG define: $display "MEM: cycle %d data_out %x tag %x" on each valid_out, using the 16-bit tics counter held at 0 during reset.

Decomposition:
- RTLinf.vh holds:
  - WRITE_FIRST/READ_FIRST constants;
  - the MEM_STATE_IDLE/MEM_STATE_CLEAR encodings;
  - MAX_READ_LATENCY=4.
- Sub-module mem_bank: one simple dual-port bank with byte enables and a 1-cycle registered read, inferable as BRAM, instantiated NUM_BANKS times.
- The top level owns:
  - bank decode;
  - the collision compare/merge;
  - the READ_LATENCY-1 output register stages carrying data, tag, valid and bank-select;
  - the clear FSM.

Test Plan (DATA_WIDTH=32, LOG_NUM_BANKS=2, NUM_ADDRESSES=64, READ_LATENCY=2, TAG_WIDTH=4):
- Write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 with tag 3 → valid_out two edges after the read, data_read=0xDEADBEEF, tag_out=3.
- Write 0x11223344 to addr 9 with be=4'hF, then 0xAABBCCDD with be=4'b0101 → a read of addr 9 returns 0x11BB33DD.
- Same-cycle write of 0x000000FF (be=4'h1) and read of addr 9 holding 0x11BB33DD:
  - WRITE_MODE=1 returns 0x11BB33FF;
  - WRITE_MODE=0 returns 0x11BB33DD;
  - a later read returns 0x11BB33FF in both modes.
- Back-to-back reads of addrs 0,1,2,3 with tags 0..3 over 4 cycles → 4 consecutive valid_out cycles with matching data and tags; banks 0..3 are exercised.
- Pulse clear → busy high for exactly 16 cycles; a read and a write issued mid-clear produce no valid and no update; afterwards every address reads 0.
- Pulse clear, then assert rst low after 5 cycles → busy=0 and valid_out=0 immediately; rows 0..4 read 0 and row 5+ keep their old data.
